// File: rtl/pdec_rd_pkg.sv
// Shared types and helpers for the LLR / partial-sum read controllers.
package pdec_rd_pkg;
  localparam int NUM_PATH    = 8;
  localparam int WID_IDX     = 3;
  localparam int MAX_NUM_PTR = 12;
  localparam int PTR_BUS_MAX = MAX_NUM_PTR * WID_IDX * NUM_PATH;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} rd_state_e;

  // Pointer field of (path, stage) from a flat table, zero-extended to the widest build.
  function automatic logic [WID_IDX-1:0] ptr_field(input logic [PTR_BUS_MAX-1:0] i_ptr,
                                                   input int i_num_ptr,
                                                   input int i_path,
                                                   input int i_stage);
    return i_ptr[(i_path * i_num_ptr + i_stage) * WID_IDX +: WID_IDX];
  endfunction
endpackage

// File: rtl/pdec_llr_rd_ctrl_if.sv
// Request, bank-read and realigned-output signals of the LLR read controller.
interface pdec_llr_rd_ctrl_if
  import pdec_rd_pkg::*;
#(
  parameter int NUM_PTR = 9,
  parameter int MEM_AW  = 8,
  parameter int WID_D   = 64,
  parameter int WID_LEN = 6
);
  logic                              rd_req;
  logic [3:0]                        rd_stage;
  logic [MEM_AW-1:0]                 rd_base;
  logic [WID_LEN-1:0]                rd_len;
  logic [NUM_PATH-1:0]               path_vld;
  logic [NUM_PTR*WID_IDX*NUM_PATH-1:0] llr_ptr;
  logic                              rd_busy;
  logic [NUM_PATH-1:0]               mem_rd_en;
  logic [MEM_AW*NUM_PATH-1:0]        mem_rd_addr;
  logic [WID_D*NUM_PATH-1:0]         mem_rd_data;
  logic                              out_vld;
  logic [WID_D*NUM_PATH-1:0]         out_data;
  logic                              out_last;
  logic                              rd_done;

  modport slave (
    input  rd_req, rd_stage, rd_base, rd_len, path_vld, llr_ptr, mem_rd_data,
    output rd_busy, mem_rd_en, mem_rd_addr, out_vld, out_data, out_last, rd_done
  );

  modport master (
    output rd_req, rd_stage, rd_base, rd_len, path_vld, llr_ptr, mem_rd_data,
    input  rd_busy, mem_rd_en, mem_rd_addr, out_vld, out_data, out_last, rd_done
  );
endinterface

// File: rtl/pdec_path_xbar.sv
// Physical-bank to logical-path data crossbar; a bank may fan out to several paths.
module pdec_path_xbar
  import pdec_rd_pkg::*;
#(
  parameter int WID_D = 64
) (
  input  logic [NUM_PATH-1:0][WID_IDX-1:0] i_sel,
  input  logic [NUM_PATH-1:0]              i_path_vld,
  input  logic [WID_D*NUM_PATH-1:0]        i_bank_data,
  output logic [WID_D*NUM_PATH-1:0]        o_data
);
  always_comb begin
    o_data = '0;
    for (int p = 0; p < NUM_PATH; p++) begin
      if (i_path_vld[p]) o_data[p*WID_D +: WID_D] = i_bank_data[int'(i_sel[p])*WID_D +: WID_D];
    end
  end
endmodule

// File: rtl/pdec_llr_rd_ctrl.sv
// LLR read controller: stage read request -> burst over the path banks, data realigned per path.
//   state | meaning
//   IDLE  | waiting for rd_req; latches base/len/paths and per-path bank select
//   ISSUE | one bank read beat per cycle
//   DRAIN | waiting for the read-latency pipe to empty
//   DONE  | rd_done pulse
module pdec_llr_rd_ctrl
  import pdec_rd_pkg::*;
#(
  parameter int NUM_PTR = 9,
  parameter int MEM_AW  = 8,
  parameter int WID_D   = 64,
  parameter int WID_LEN = 6,
  parameter int RD_LAT  = 2
) (
  input  logic              clk,
  input  logic              rst,
  pdec_llr_rd_ctrl_if.slave bus
);
  localparam logic [RD_LAT-1:0] PIPE_OUT = RD_LAT'(1) << (RD_LAT - 1);

  rd_state_e                        r_state;
  logic [MEM_AW-1:0]                r_base;
  logic [WID_LEN-1:0]               r_len;
  logic [WID_LEN-1:0]               r_k;
  logic [NUM_PATH-1:0]              r_pvld;
  logic [NUM_PATH-1:0]              r_mask;
  logic [NUM_PATH-1:0][WID_IDX-1:0] r_sel;
  logic [RD_LAT-1:0]                r_pipe_vld;
  logic [RD_LAT-1:0]                r_pipe_last;

  logic [3:0]                       w_stage;
  logic [NUM_PATH-1:0][WID_IDX-1:0] w_sel_nxt;
  logic [NUM_PATH-1:0]              w_mask_nxt;
  logic                             w_issue;
  logic                             w_last_beat;
  logic                             w_pipe_busy;
  logic [MEM_AW*NUM_PATH-1:0]       w_addr;

  // Out-of-range stages fall back to stage 0, matching the pointer writer.
  always_comb begin
    w_stage    = (int'(bus.rd_stage) >= NUM_PTR) ? 4'd0 : bus.rd_stage;
    w_sel_nxt  = '0;
    w_mask_nxt = '0;
    for (int p = 0; p < NUM_PATH; p++)
      w_sel_nxt[p] = ptr_field(PTR_BUS_MAX'(bus.llr_ptr), NUM_PTR, p, int'(w_stage));
    for (int b = 0; b < NUM_PATH; b++)
      for (int p = 0; p < NUM_PATH; p++)
        if (bus.path_vld[p] && (w_sel_nxt[p] == WID_IDX'(b))) w_mask_nxt[b] = 1'b1;
  end

  assign w_issue     = (r_state == ISSUE);
  assign w_last_beat = w_issue && (r_k == r_len - WID_LEN'(1));
  assign w_pipe_busy = |(r_pipe_vld & ~PIPE_OUT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_base      <= '0;
      r_len       <= '0;
      r_k         <= '0;
      r_pvld      <= '0;
      r_mask      <= '0;
      r_sel       <= '0;
      r_pipe_vld  <= '0;
      r_pipe_last <= '0;
    end else begin
      r_pipe_vld[0]  <= w_issue;
      r_pipe_last[0] <= w_last_beat;
      for (int i = 1; i < RD_LAT; i++) begin
        r_pipe_vld[i]  <= r_pipe_vld[i-1];
        r_pipe_last[i] <= r_pipe_last[i-1];
      end
      case (r_state)
        IDLE: begin
          if (bus.rd_req) begin
            r_base  <= bus.rd_base;
            r_len   <= bus.rd_len;
            r_pvld  <= bus.path_vld;
            r_sel   <= w_sel_nxt;
            r_mask  <= w_mask_nxt;
            r_k     <= '0;
            r_state <= (bus.rd_len == '0) ? DONE : ISSUE;
          end
        end
        ISSUE: begin
          if (w_last_beat) r_state <= DRAIN;
          else             r_k     <= r_k + WID_LEN'(1);
        end
        DRAIN:   if (!w_pipe_busy) r_state <= DONE;
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    w_addr = '0;
    for (int b = 0; b < NUM_PATH; b++)
      if (w_issue && r_mask[b]) w_addr[b*MEM_AW +: MEM_AW] = r_base + MEM_AW'(r_k);
  end

  assign bus.rd_busy     = (r_state != IDLE);
  assign bus.mem_rd_en   = w_issue ? r_mask : '0;
  assign bus.mem_rd_addr = w_addr;
  assign bus.out_vld     = r_pipe_vld[RD_LAT-1];
  assign bus.out_last    = r_pipe_last[RD_LAT-1];
  assign bus.rd_done     = (r_state == DONE);

  pdec_path_xbar #(.WID_D(WID_D)) u_xbar (
    .i_sel       (r_sel),
    .i_path_vld  (r_pvld),
    .i_bank_data (bus.mem_rd_data),
    .o_data      (bus.out_data)
  );
endmodule

// File: tb/tb_pdec_llr_rd_ctrl.sv
// Randomized bench for pdec_llr_rd_ctrl against a cycle-scheduled burst model.
module tb_pdec_llr_rd_ctrl;
  import pdec_rd_pkg::*;

  localparam int NUM_PTR = 9;
  localparam int MEM_AW  = 8;
  localparam int WID_D   = 64;
  localparam int WID_LEN = 6;
  localparam int RD_LAT  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pdec_llr_rd_ctrl_if #(.NUM_PTR(NUM_PTR), .MEM_AW(MEM_AW), .WID_D(WID_D), .WID_LEN(WID_LEN)) bus_if ();

  pdec_llr_rd_ctrl #(.NUM_PTR(NUM_PTR), .MEM_AW(MEM_AW), .WID_D(WID_D), .WID_LEN(WID_LEN),
                     .RD_LAT(RD_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  // Bank contents: each bank returns a word tagged with its own index and the address read.
  function automatic logic [63:0] bank_word(input int b, input logic [7:0] a);
    return {4'hB, 4'(b), a, ~a, 8'(b * 17), 32'h600D_0000 + 32'(a)};
  endfunction

  logic [7:0]                m_en   [RD_LAT];
  logic [MEM_AW*8-1:0]       m_addr [RD_LAT];
  logic [WID_D*8-1:0]        w_mem_data;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) begin
        m_en[i]   <= '0;
        m_addr[i] <= '0;
      end
    end else begin
      m_en[0]   <= bus_if.mem_rd_en;
      m_addr[0] <= bus_if.mem_rd_addr;
      for (int i = 1; i < RD_LAT; i++) begin
        m_en[i]   <= m_en[i-1];
        m_addr[i] <= m_addr[i-1];
      end
    end
  end

  always_comb begin
    w_mem_data = '0;
    for (int b = 0; b < 8; b++)
      w_mem_data[b*64 +: 64] = m_en[RD_LAT-1][b] ? bank_word(b, m_addr[RD_LAT-1][b*8 +: 8])
                                                 : (64'hDEAD_BEEF_0000_0000 | 64'(b));
  end
  assign bus_if.mem_rd_data = w_mem_data;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;
  int free_cyc = 0;
  int busy_lo = 0;
  int busy_hi = -1;

  logic [2:0]           ptab [8][NUM_PTR];
  logic [7:0]           e_en   [int];
  logic [MEM_AW*8-1:0]  e_addr [int];
  bit                   e_vld  [int];
  bit                   e_last [int];
  logic [WID_D*8-1:0]   e_data [int];
  bit                   e_done [int];

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic set_ptr();
    for (int p = 0; p < 8; p++)
      for (int s = 0; s < NUM_PTR; s++)
        bus_if.llr_ptr[(p*NUM_PTR + s)*3 +: 3] = ptab[p][s];
  endtask

  task automatic model_clear();
    e_en.delete(); e_addr.delete(); e_vld.delete();
    e_last.delete(); e_data.delete(); e_done.delete();
    busy_hi  = -1;
    free_cyc = 0;
  endtask

  // Schedule every output of an accepted request at absolute cycle numbers.
  task automatic model_accept(input int stage, input logic [7:0] base, input int len, input logic [7:0] pvld);
    int         st;
    int         t;
    logic [2:0] sel [8];
    logic [7:0] mask;
    logic [7:0] a;
    logic [MEM_AW*8-1:0] ad;
    logic [WID_D*8-1:0]  d;
    st   = (stage >= NUM_PTR) ? 0 : stage;
    t    = cyc;
    mask = '0;
    for (int p = 0; p < 8; p++) begin
      sel[p] = ptab[p][st];
      if (pvld[p]) mask[sel[p]] = 1'b1;
    end
    if (len == 0) begin
      e_done[t+1] = 1'b1;
      busy_lo  = t + 1;
      busy_hi  = t + 1;
    end else begin
      for (int k = 0; k < len; k++) begin
        a  = base + 8'(k);
        ad = '0;
        d  = '0;
        for (int b = 0; b < 8; b++) if (mask[b]) ad[b*8 +: 8] = a;
        for (int p = 0; p < 8; p++) if (pvld[p]) d[p*64 +: 64] = bank_word(int'(sel[p]), a);
        e_en[t+1+k]          = mask;
        e_addr[t+1+k]        = ad;
        e_vld[t+1+k+RD_LAT]  = 1'b1;
        e_last[t+1+k+RD_LAT] = (k == len - 1);
        e_data[t+1+k+RD_LAT] = d;
      end
      e_done[t+len+RD_LAT+1] = 1'b1;
      busy_lo = t + 1;
      busy_hi = t + len + RD_LAT + 1;
    end
    free_cyc = busy_hi + 1;
  endtask

  task automatic check_cycle();
    bit xv;
    xv = e_vld.exists(cyc) ? e_vld[cyc] : 1'b0;
    check("busy", bus_if.rd_busy, (cyc >= busy_lo && cyc <= busy_hi));
    check("rd_en", bus_if.mem_rd_en, e_en.exists(cyc) ? e_en[cyc] : 8'h00);
    check("rd_addr", bus_if.mem_rd_addr, e_addr.exists(cyc) ? e_addr[cyc] : '0);
    check("out_vld", bus_if.out_vld, xv);
    check("out_last", bus_if.out_last, e_last.exists(cyc) ? e_last[cyc] : 1'b0);
    check("rd_done", bus_if.rd_done, e_done.exists(cyc) ? e_done[cyc] : 1'b0);
    if (xv) check("out_data", bus_if.out_data, e_data[cyc]);
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    check_cycle();
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic issue(input int stage, input logic [7:0] base, input int len, input logic [7:0] pvld);
    bus_if.rd_req   = 1'b1;
    bus_if.rd_stage = 4'(stage);
    bus_if.rd_base  = base;
    bus_if.rd_len   = WID_LEN'(len);
    bus_if.path_vld = pvld;
    if (!rst && cyc >= free_cyc) model_accept(stage, base, len, pvld);
    step();
    bus_if.rd_req = 1'b0;
  endtask

  task automatic rand_ptab();
    for (int p = 0; p < 8; p++)
      for (int s = 0; s < NUM_PTR; s++) ptab[p][s] = 3'($urandom_range(0, 7));
    set_ptr();
  endtask

  initial begin
    logic [2:0] t2_sel [8];
    int len;
    logic [7:0] pv;
    t2_sel = '{3'd7, 3'd7, 3'd2, 3'd2, 3'd0, 3'd0, 3'd0, 3'd5};

    bus_if.rd_req   = 1'b0;
    bus_if.rd_stage = '0;
    bus_if.rd_base  = '0;
    bus_if.rd_len   = '0;
    bus_if.path_vld = '0;
    bus_if.llr_ptr  = '0;
    for (int p = 0; p < 8; p++)
      for (int s = 0; s < NUM_PTR; s++) ptab[p][s] = 3'(p);
    set_ptr();

    idle(3);
    rst = 1'b0;
    idle(2);

    // identity pointers, 4-beat burst
    issue(0, 8'h10, 4, 8'hFF);
    check("t1_addr_bank0", bus_if.mem_rd_addr[7:0], 8'h10);
    idle(8);

    // lazy-copied pointers on stage 3
    for (int p = 0; p < 8; p++) ptab[p][3] = t2_sel[p];
    set_ptr();
    issue(3, 8'h40, 2, 8'hFF);
    check("t2_mask", bus_if.mem_rd_en, 8'hA5);
    idle(6);

    // half the paths, single beat
    issue(3, 8'h22, 1, 8'h0F);
    idle(5);

    // address wrap, request and pointer change during burst
    issue(1, 8'hFE, 3, 8'hFF);
    issue(5, 8'h20, 7, 8'h0F);
    rand_ptab();
    idle(7);

    // empty burst, then out-of-range stage
    issue(12, 8'h33, 0, 8'hFF);
    check("t5_done", bus_if.rd_done, 1'b1);
    idle(2);
    rand_ptab();
    issue(12, 8'h50, 2, 8'hFF);
    idle(6);

    // reset in the middle of a burst
    issue(0, 8'h60, 4, 8'hFF);
    step();
    rst = 1'b1;
    model_clear();
    #1;
    check("rst_en", bus_if.mem_rd_en, 8'h00);
    check("rst_vld", bus_if.out_vld, 1'b0);
    check("rst_busy", bus_if.rd_busy, 1'b0);
    idle(3);
    rst = 1'b0;
    idle(4);
    issue(2, 8'h70, 3, 8'hF0);
    idle(8);

    // randomized traffic, including requests that land while busy
    for (int it = 0; it < 300; it++) begin
      if ($urandom_range(0, 3) == 0) rand_ptab();
      len = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 5));
      case ($urandom_range(0, 3))
        0:       pv = 8'h00;
        1:       pv = 8'hFF;
        default: pv = 8'($urandom);
      endcase
      issue(int'($urandom_range(0, 15)), 8'($urandom), len, pv);
      if ($urandom_range(0, 1) == 0) begin
        for (int g = 0; g < 80 && cyc < free_cyc; g++) begin
          if ($urandom_range(0, 7) == 0) begin
            issue(int'($urandom_range(0, 15)), 8'($urandom), int'($urandom_range(1, 4)), 8'($urandom));
            rand_ptab();
          end else begin
            step();
          end
        end
      end else begin
        idle(int'($urandom_range(0, 3)));
      end
    end
    idle(80);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
